// File: rtl/uart_mux_pkg.sv
// Shared definitions for the UART <-> USB byte-pair mux/demux: pair-walker
// state encodings and the channel index width.
package uart_mux_pkg;

    // The channel index travels as one full byte on the USB stream.
    localparam int unsigned UART_INDEX_BITS = 8;

    typedef enum logic [1:0] {
        ST_INDEX        = 2'd0,
        ST_INDEX_SETTLE = 2'd1,
        ST_VALUE        = 2'd2,
        ST_VALUE_SETTLE = 2'd3
    } uart_mux_state_t;

endpackage

// File: rtl/uart_out_demux_sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping.
module sat_counter #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (inc && (count_q != '1)) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/uart_out_demux.sv
// USB -> UART demux: pops (index, value) byte pairs from the USB RX FIFO and
// writes the value into the addressed UART TX FIFO, dropping out-of-range pairs.
module uart_out_demux
    import uart_mux_pkg::*;
#(
    parameter int unsigned DATA_BITS    = UART_INDEX_BITS,
    parameter int unsigned COUNTER_BITS = 16,
    parameter int unsigned UART_COUNT   = 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    fifo_empty,
    output logic                    fifo_read,
    input  logic [DATA_BITS-1:0]    fifo_data,
    output logic [UART_COUNT-1:0]   write,
    input  logic [UART_COUNT-1:0]   full,
    output logic [DATA_BITS-1:0]    data,
    output logic [COUNTER_BITS-1:0] drop_count
);

    uart_mux_state_t       state_q, state_d;
    logic [DATA_BITS-1:0]  index_q, index_d;
    logic [DATA_BITS-1:0]  data_q, data_d;
    logic                  fifo_read_q, fifo_read_d;
    logic [UART_COUNT-1:0] write_q, write_d;
    logic [UART_COUNT-1:0] sel;
    logic                  index_valid;
    logic                  target_full;
    logic                  drop_inc;

    // Full-width index decode: any index >= UART_COUNT matches no channel.
    always_comb begin
        sel = '0;
        for (int unsigned i = 0; i < UART_COUNT; i++) begin
            if (index_q == DATA_BITS'(i)) begin
                sel[i] = 1'b1;
            end
        end
    end

    assign index_valid = |sel;
    assign target_full = |(sel & full);

    always_comb begin
        state_d     = state_q;
        index_d     = index_q;
        fifo_read_d = 1'b0;
        write_d     = '0;
        data_d      = '0;
        drop_inc    = 1'b0;
        case (state_q)
            ST_INDEX: begin
                if (!fifo_empty) begin
                    index_d     = fifo_data;
                    fifo_read_d = 1'b1;
                    state_d     = ST_INDEX_SETTLE;
                end
            end
            ST_INDEX_SETTLE: begin
                state_d = ST_VALUE;
            end
            ST_VALUE: begin
                if (!fifo_empty) begin
                    if (index_valid) begin
                        // A full target stalls the stream with the value byte left unread.
                        if (!target_full) begin
                            write_d     = sel;
                            data_d      = fifo_data;
                            fifo_read_d = 1'b1;
                            state_d     = ST_VALUE_SETTLE;
                        end
                    end else begin
                        fifo_read_d = 1'b1;
                        drop_inc    = 1'b1;
                        state_d     = ST_VALUE_SETTLE;
                    end
                end
            end
            ST_VALUE_SETTLE: begin
                state_d = ST_INDEX;
            end
            default: begin
                state_d = ST_INDEX;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_INDEX;
            index_q     <= '0;
            fifo_read_q <= 1'b0;
            write_q     <= '0;
            data_q      <= '0;
        end else begin
            state_q     <= state_d;
            index_q     <= index_d;
            fifo_read_q <= fifo_read_d;
            write_q     <= write_d;
            data_q      <= data_d;
        end
    end

    sat_counter #(
        .WIDTH(COUNTER_BITS)
    ) u_drop_counter (
        .clk   (clk),
        .reset (reset),
        .inc   (drop_inc),
        .count (drop_count)
    );

    assign fifo_read = fifo_read_q;
    assign write     = write_q;
    assign data      = data_q;

endmodule
